// File: rtl/nibble_link_pkg.sv
// Shared definitions for the phase-slotted nibble link: sequencer states,
// phase-count width, default capture slots and the slot-decode helper.
package nibble_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int PHASE_W = 3;

  localparam logic [PHASE_W-1:0] PHASE_ZERO = 3'd0;
  localparam logic [PHASE_W-1:0] PHASE_ONE  = 3'd1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd7;

  localparam logic [PHASE_W-1:0] SLOT_A_DEF = 3'd4;
  localparam logic [PHASE_W-1:0] SLOT_B_DEF = 3'd6;

  // True when the given phase is one of the two capture slots of a frame.
  function automatic logic is_slot(
    input logic [PHASE_W-1:0] phase,
    input logic [PHASE_W-1:0] slot_a = SLOT_A_DEF,
    input logic [PHASE_W-1:0] slot_b = SLOT_B_DEF
  );
    return (phase == slot_a) || (phase == slot_b);
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO used as the input buffer of the nibble transmitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. A push while full is ignored even if
// a pop happens on the same edge; the storage array itself is not reset,
// clearing the pointers is enough to discard any buffered words.
module nibble_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Advance write/read pointers on accepted push/pop; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Write the incoming word into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/nibble_phase_tx.sv
// Transmit side of the phase-slotted nibble link. Buffers producer words and
// drives the 3-bit phase count plus the data nibble. A word is loaded into a0
// on the edge where the phase enters a capture slot, so a0 is stable for the
// whole cycle in which clk_out shows that slot value.
module nibble_phase_tx
  import nibble_link_pkg::*;
#(
  parameter int                 DATA_W     = 4,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [PHASE_W-1:0] SLOT_A     = SLOT_A_DEF,
  parameter logic [PHASE_W-1:0] SLOT_B     = SLOT_B_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic [PHASE_W-1:0] clk_out,
  output logic [DATA_W-1:0]  a0,
  output logic               strobe,
  output logic               underrun,
  output logic               busy
);

  state_t             r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [DATA_W-1:0]  r_a0;
  logic               r_strobe;
  logic               r_underrun;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic               w_slot_nxt;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [DATA_W-1:0]  w_head;

  nibble_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (in_valid),
    .i_wdata (in_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Next sequencer state and phase; DRAIN finishes the current frame before idling.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = PHASE_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = PHASE_ZERO;
        end
      end
      ST_RUN: begin
        if (!enable && (r_phase == PHASE_LAST)) begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = PHASE_ZERO;
        end else if (!enable) begin
          w_state_nxt = ST_DRAIN;
          w_phase_nxt = r_phase + PHASE_ONE;
        end else begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = r_phase + PHASE_ONE;
        end
      end
      ST_DRAIN: begin
        if (r_phase == PHASE_LAST) begin
          w_state_nxt = enable ? ST_RUN : ST_IDLE;
          w_phase_nxt = PHASE_ZERO;
        end else if (enable) begin
          w_state_nxt = ST_RUN;
          w_phase_nxt = r_phase + PHASE_ONE;
        end else begin
          w_state_nxt = ST_DRAIN;
          w_phase_nxt = r_phase + PHASE_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = PHASE_ZERO;
      end
    endcase
  end

  // A slot load happens when the upcoming phase is a capture slot; IDLE never loads.
  always_comb begin
    w_slot_nxt = (w_state_nxt != ST_IDLE) && is_slot(w_phase_nxt, SLOT_A, SLOT_B);
    if (w_slot_nxt && !w_empty) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
  end

  // Sequencer registers plus registered link outputs loaded at slot edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_phase    <= PHASE_ZERO;
      r_a0       <= '0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_strobe <= w_slot_nxt;
      if (w_pop) begin
        r_a0       <= w_head;
        r_underrun <= 1'b0;
      end else if (w_slot_nxt) begin
        r_a0       <= r_a0;
        r_underrun <= 1'b1;
      end else begin
        r_a0       <= r_a0;
        r_underrun <= 1'b0;
      end
    end
  end

  assign in_ready = !w_full;
  assign clk_out  = r_phase;
  assign a0       = r_a0;
  assign strobe   = r_strobe;
  assign underrun = r_underrun;
  assign busy     = r_busy;

endmodule

// File: tb/tb_nibble_phase_tx.sv
// Directed bench for nibble_phase_tx. Each step drives inputs, waits one
// clock, then compares every output against hand-chosen phase/busy values
// and a small FIFO scoreboard of the words expected on a0.
module tb_nibble_phase_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [2:0] clk_out;
  logic [3:0] a0;
  logic       strobe;
  logic       underrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q [$];
  logic [3:0] exp_a0;
  logic       last_acc;
  logic [2:0] ph;
  logic       pend;
  logic [3:0] seq;
  logic [3:0] w2 [4];
  logic [3:0] w3 [4];

  nibble_phase_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clk_out  (clk_out),
    .a0       (a0),
    .strobe   (strobe),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, ".clk_out"},  8'(clk_out),  8'd0);
    chk({tag, ".a0"},       8'(a0),       8'd0);
    chk({tag, ".strobe"},   8'(strobe),   8'd0);
    chk({tag, ".underrun"}, 8'(underrun), 8'd0);
    chk({tag, ".busy"},     8'(busy),     8'd0);
    chk({tag, ".in_ready"}, 8'(in_ready), 8'd1);
  endtask

  // One clock: drive, step, update scoreboard (slot pop before push), compare.
  task automatic cyc(input string tag, input logic v, input logic [3:0] d,
                     input logic [2:0] eph, input logic ebusy);
    logic acc;
    logic es;
    logic eun;
    in_valid = v;
    in_data  = d;
    acc = v && (exp_q.size() < 4);
    @(posedge clk);
    #1;
    if (eph == 3'd4 || eph == 3'd6) begin
      es = 1'b1;
      if (exp_q.size() != 0) begin
        exp_a0 = exp_q.pop_front();
        eun = 1'b0;
      end else begin
        eun = 1'b1;
      end
    end else begin
      es  = 1'b0;
      eun = 1'b0;
    end
    if (acc) exp_q.push_back(d);
    last_acc = acc;
    chk({tag, ".clk_out"},  8'(clk_out),  8'(eph));
    chk({tag, ".strobe"},   8'(strobe),   8'(es));
    chk({tag, ".underrun"}, 8'(underrun), 8'(eun));
    chk({tag, ".a0"},       8'(a0),       8'(exp_a0));
    chk({tag, ".busy"},     8'(busy),     8'(ebusy));
    chk({tag, ".in_ready"}, 8'(in_ready), 8'(exp_q.size() < 4));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    exp_a0 = 4'h0; last_acc = 1'b0; ph = 3'd0; pend = 1'b0; seq = 4'h1;
    w2 = '{4'hA, 4'h3, 4'h5, 4'hC};
    w3 = '{4'h1, 4'h2, 4'h4, 4'h8};
    #3 rst_n = 1'b0;
    #1 reset_chk("rst0");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Test 1: fill 4 words in IDLE, run to clk_out=5 (3 left), reset mid-frame.
    for (int i = 0; i < 4; i++) cyc("t1.fill", 1'b1, 4'(i + 1), 3'd0, 1'b0);
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) cyc("t1.run", 1'b0, 4'h0, 3'(i), 1'b1);
    #2 rst_n = 1'b0;
    #1 reset_chk("t1.rst");
    exp_q.delete();
    exp_a0 = 4'h0;
    enable = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_chk("t1.hold");
    rst_n = 1'b1;

    // Test 2: push A,3,5,C while starting from IDLE with enable=1.
    enable = 1'b1;
    ph = 3'd0;
    for (int i = 0; i < 14; i++) begin
      ph = ph + 3'd1;
      if (i < 4) cyc("t2", 1'b1, w2[i], ph, 1'b1);
      else       cyc("t2", 1'b0, 4'h0, ph, 1'b1);
    end
    enable = 1'b0;
    cyc("t2.stop", 1'b0, 4'h0, 3'd7, 1'b1);
    cyc("t2.stop", 1'b0, 4'h0, 3'd0, 1'b0);

    // Test 3: five back-to-back words with enable=0; fifth held until room.
    for (int i = 0; i < 4; i++) cyc("t3.fill", 1'b1, w3[i], 3'd0, 1'b0);
    cyc("t3.hold", 1'b1, 4'hF, 3'd0, 1'b0);
    cyc("t3.hold", 1'b1, 4'hF, 3'd0, 1'b0);
    enable = 1'b1;
    pend = 1'b1;
    ph = 3'd0;
    for (int i = 0; i < 20; i++) begin
      ph = ph + 3'd1;
      cyc("t3.run", pend, 4'hF, ph, 1'b1);
      if (last_acc) pend = 1'b0;
    end

    // Test 4: empty buffer underruns; 0x9 pushed at clk_out=3 appears at 6.
    for (int i = 0; i < 10; i++) begin
      ph = ph + 3'd1;
      cyc("t4", (i == 7), 4'h9, ph, 1'b1);
    end

    // Test 5: drop enable at clk_out=2, frame completes; then reassert mid-drain.
    ph = ph + 3'd1; cyc("t5.load", 1'b1, 4'h6, ph, 1'b1);
    ph = ph + 3'd1; cyc("t5.load", 1'b1, 4'hD, ph, 1'b1);
    ph = ph + 3'd1; cyc("t5.load", 1'b0, 4'h0, ph, 1'b1);
    ph = ph + 3'd1; cyc("t5.load", 1'b0, 4'h0, ph, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ph = ph + 3'd1;
      cyc("t5.drain", 1'b0, 4'h0, ph, 1'b1);
    end
    ph = ph + 3'd1; cyc("t5.idle", 1'b0, 4'h0, ph, 1'b0);
    enable = 1'b1;
    ph = ph + 3'd1; cyc("t5.rerun", 1'b0, 4'h0, ph, 1'b1);
    ph = ph + 3'd1; cyc("t5.rerun", 1'b0, 4'h0, ph, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ph = ph + 3'd1;
      cyc("t5.drain2", 1'b0, 4'h0, ph, 1'b1);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ph = ph + 3'd1;
      cyc("t5.resume", 1'b0, 4'h0, ph, 1'b1);
    end

    // Test 6: continuous producer while running; full coincides with slot pops.
    for (int i = 0; i < 24; i++) begin
      ph = ph + 3'd1;
      cyc("t6", 1'b1, seq, ph, 1'b1);
      if (last_acc) seq = seq + 4'h1;
    end
    in_valid = 1'b0;
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
